// File: rtl/img_pkg.sv
// Shared constants and writer state encoding for the image DDR path.
// Imported by img_ddr_writer.
package img_pkg;

  localparam int LINE_WORDS   = 256;
  localparam int IMAGE_WORDS  = 262144;
  localparam int PACKET_WORDS = IMAGE_WORDS + LINE_WORDS;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam logic [1:0] FT_2D = 2'd0;
  localparam logic [1:0] FT_3D = 2'd1;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    WR_COMMIT
  } wr_state_t;

endpackage

// File: rtl/img_ddr_writer.sv
// Drains the FWFT packet FIFO into DDR as fixed-length AXI4 INCR bursts.
// Ports: FIFO read side, frame_store in, AXI4 AW/W/B master, frame_done/status out.
module img_ddr_writer
  import img_pkg::*;
#(
  parameter int                    ADDR_WIDTH       = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = 'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE     = 'h0020_0000,
  parameter int                    NUM_BUF          = 4,
  parameter int                    BURST_LEN        = 256,
  parameter int                    BURSTS_PER_FRAME = 1025,
  parameter int                    CNT_WIDTH        = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [31:0]                fifo_rddata,
  input  logic                       fifo_empty,
  input  logic [CNT_WIDTH-1:0]       fifo_rd_count,
  output logic                       fifo_rden,
  input  logic                       frame_store,
  input  logic [1:0]                 frame_type_i,
  output logic [ADDR_WIDTH-1:0]      m_axi_awaddr,
  output logic [7:0]                 m_axi_awlen,
  output logic [2:0]                 m_axi_awsize,
  output logic [1:0]                 m_axi_awburst,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,
  output logic [31:0]                m_axi_wdata,
  output logic [3:0]                 m_axi_wstrb,
  output logic                       m_axi_wlast,
  output logic                       m_axi_wvalid,
  input  logic                       m_axi_wready,
  input  logic [1:0]                 m_axi_bresp,
  input  logic                       m_axi_bvalid,
  output logic                       m_axi_bready,
  output logic                       frame_done,
  output logic [$clog2(NUM_BUF)-1:0] frame_done_buf,
  output logic [1:0]                 frame_done_type,
  output logic                       busy,
  output logic                       resp_err,
  output logic                       store_overrun,
  output logic                       fifo_underrun
);

  localparam int BUF_W = $clog2(NUM_BUF);

  localparam logic [7:0] LAST_BEAT =
    8'(BURST_LEN - 1);
  localparam logic [10:0] LAST_BURST =
    11'(BURSTS_PER_FRAME - 1);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES =
    ADDR_WIDTH'(BURST_LEN * 4);
  localparam logic [CNT_WIDTH-1:0] START_LVL =
    CNT_WIDTH'(BURST_LEN);

  wr_state_t        state;
  logic [BUF_W-1:0] buf_idx;
  logic [10:0]      burst_cnt;
  logic [7:0]       beat_cnt;
  logic             store_pend;
  logic [1:0]       type_q;

  logic                  commit;
  logic                  start;
  logic [ADDR_WIDTH-1:0] next_addr;

  assign m_axi_awlen   = 8'(BURST_LEN - 1);
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wdata   = fifo_rddata;
  assign m_axi_wlast   = m_axi_wvalid &&
                         (beat_cnt == LAST_BEAT);
  assign fifo_rden     = m_axi_wvalid && m_axi_wready;
  assign busy          = (state != WR_IDLE) ||
                         (burst_cnt != '0);

  // A store pulse in the COMMIT cycle itself is enough to commit.
  assign commit = (state == WR_COMMIT) &&
                  (store_pend || frame_store);
  assign start  = enable &&
                  (fifo_rd_count >= START_LVL);

  assign next_addr = BASE_ADDR
    + ADDR_WIDTH'(buf_idx) * FRAME_STRIDE
    + ADDR_WIDTH'(burst_cnt) * BURST_BYTES;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= WR_IDLE;
      buf_idx         <= '0;
      burst_cnt       <= '0;
      beat_cnt        <= '0;
      store_pend      <= 1'b0;
      type_q          <= '0;
      m_axi_awaddr    <= '0;
      m_axi_awvalid   <= 1'b0;
      m_axi_wvalid    <= 1'b0;
      m_axi_bready    <= 1'b0;
      frame_done      <= 1'b0;
      frame_done_buf  <= '0;
      frame_done_type <= '0;
      resp_err        <= 1'b0;
      store_overrun   <= 1'b0;
      fifo_underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (m_axi_wvalid && fifo_empty)
        fifo_underrun <= 1'b1;

      // A store landing while the previous one is being
      // committed belongs to the next frame.
      if (frame_store && store_pend && !commit)
        store_overrun <= 1'b1;
      if (frame_store && (!store_pend || commit))
        type_q <= frame_type_i;
      if (commit)
        store_pend <= store_pend && frame_store;
      else if (frame_store)
        store_pend <= 1'b1;

      unique case (state)
        WR_IDLE: begin
          if (start) begin
            m_axi_awaddr  <= next_addr;
            m_axi_awvalid <= 1'b1;
            state         <= WR_ADDR;
          end
        end
        WR_ADDR: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b1;
            beat_cnt      <= '0;
            state         <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (m_axi_wready) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (beat_cnt == LAST_BEAT) begin
              m_axi_wvalid <= 1'b0;
              m_axi_bready <= 1'b1;
              state        <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp != AXI_RESP_OKAY)
              resp_err <= 1'b1;
            if (burst_cnt == LAST_BURST) begin
              state <= WR_COMMIT;
            end else begin
              burst_cnt <= burst_cnt + 11'd1;
              state     <= WR_IDLE;
            end
          end
        end
        WR_COMMIT: begin
          if (commit) begin
            frame_done      <= 1'b1;
            frame_done_buf  <= buf_idx;
            frame_done_type <= store_pend ? type_q
                                          : frame_type_i;
            burst_cnt       <= '0;
            buf_idx         <= buf_idx + 1'b1;
            state           <= WR_IDLE;
          end
        end
        default: state <= WR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_ddr_writer.sv
// Self-checking bench for img_ddr_writer (short frames of 8 bursts).
// Table of frame scenarios plus hand sequences for reset and count hold.
module tb_img_ddr_writer;
  import img_pkg::*;

  localparam int BL  = 256;
  localparam int BPF = 8;
  localparam int FW  = BL * BPF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] fifo_rddata;
  logic        fifo_empty;
  logic [10:0] fifo_rd_count;
  logic        fifo_rden;
  logic        frame_store = 1'b0;
  logic [1:0]  frame_type_i = 2'b11;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic        frame_done;
  logic [1:0]  frame_done_buf;
  logic [1:0]  frame_done_type;
  logic        busy;
  logic        resp_err;
  logic        store_overrun;
  logic        fifo_underrun;

  int checks = 0;
  int failures = 0;

  int unsigned pushed = 0;
  int unsigned popped = 0;
  int unsigned cyc = 0;

  bit          bp_en = 0;
  int          err_burst = 99;
  int          b_pending = 0;
  int          burst_idx = 0;
  int          beat = 0;
  int unsigned exp_word = 0;
  int          frame_beats = 0;
  bit          aw_open = 0;
  bit          no_aw = 0;
  bit          no_fd = 0;
  bit          prev_fd = 0;
  int          fd_cnt = 0;
  logic [1:0]  fd_buf;
  logic [1:0]  fd_type;
  int unsigned fd_cyc = 0;
  int unsigned last_b_cyc = 0;
  logic [31:0] aw_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (fifo_rden) popped <= popped + 1;

  assign fifo_rddata   = popped;
  assign fifo_empty    = (pushed == popped);
  assign fifo_rd_count = (pushed - popped > 2047) ?
                         11'd2047 : 11'(pushed - popped);

  img_ddr_writer #(.BURSTS_PER_FRAME(BPF)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fifo_rddata(fifo_rddata),
    .fifo_empty(fifo_empty),
    .fifo_rd_count(fifo_rd_count),
    .fifo_rden(fifo_rden),
    .frame_store(frame_store),
    .frame_type_i(frame_type_i),
    .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .frame_done(frame_done),
    .frame_done_buf(frame_done_buf),
    .frame_done_type(frame_done_type),
    .busy(busy),
    .resp_err(resp_err),
    .store_overrun(store_overrun),
    .fifo_underrun(fifo_underrun)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // AXI slave + monitor: drives ready/B at negedge, checks at negedge+1.
  initial begin
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    forever begin
      @(negedge clk);
      m_axi_awready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_wready  = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_bvalid  = (b_pending > 0) &&
                      (bp_en ? 1'($urandom_range(0, 1)) : 1'b1);
      m_axi_bresp   = (burst_idx == err_burst) ? 2'b10 : 2'b00;
      #1;
      if (no_aw) chk("hold_awvalid", m_axi_awvalid, 0);
      if (no_fd) chk("hold_frame_done", frame_done, 0);
      if (m_axi_awvalid && m_axi_awready) begin
        aw_q.push_back(m_axi_awaddr);
        aw_open = 1;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        chk("w_after_aw", aw_open, 1);
        chk("wdata", m_axi_wdata, exp_word);
        chk("wlast", m_axi_wlast, beat == BL - 1);
        exp_word++;
        frame_beats++;
        if (beat == BL - 1) begin
          beat = 0;
          aw_open = 0;
          b_pending++;
        end else begin
          beat++;
        end
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_pending--;
        burst_idx++;
        last_b_cyc = cyc;
      end
      if (frame_done) begin
        chk("fd_one_cycle", prev_fd, 0);
        fd_cnt++;
        fd_buf  = frame_done_buf;
        fd_type = frame_done_type;
        fd_cyc  = cyc;
        burst_idx = 0;
      end
      prev_fd = frame_done;
      if (!rst_n) begin
        b_pending = 0;
        burst_idx = 0;
        beat = 0;
        aw_open = 0;
      end
    end
  end

  typedef struct {
    bit          bp;
    int          err;
    int          mode;   // 0 mid, 1 delayed, 2 double store
    bit          hold;
    logic [1:0]  typ;
    logic [1:0]  exp_buf;
    logic [31:0] exp_addr;
    bit          exp_rerr;
    bit          exp_ovr;
  } fvec_t;

  fvec_t tbl[6];

  task automatic pulse_store(input logic [1:0] t,
                             output int unsigned sc);
    @(negedge clk);
    frame_store  = 1'b1;
    frame_type_i = t;
    sc = cyc;
    @(negedge clk);
    frame_store  = 1'b0;
    frame_type_i = 2'b11;
  endtask

  task automatic wait_bursts(input int n);
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      #2;
      if (burst_idx >= n) return;
    end
    chk("wait_bursts_timeout", burst_idx, n);
  endtask

  task automatic run_frame(input fvec_t v);
    int unsigned sc;
    int fd0;
    int n;
    sc = 0;
    bp_en = v.bp;
    err_burst = v.err;
    frame_beats = 0;
    aw_q.delete();
    fd0 = fd_cnt;
    enable = 1'b1;
    if (v.hold) begin
      pushed += BL - 1;
      no_aw = 1;
      repeat (100) @(negedge clk);
      no_aw = 0;
      pushed += FW - (BL - 1);
    end else begin
      pushed += FW;
    end
    if (v.mode == 1) begin
      wait_bursts(BPF);
      no_aw = 1;
      no_fd = 1;
      repeat (500) @(negedge clk);
      chk("commit_busy", busy, 1);
      no_aw = 0;
      no_fd = 0;
      pulse_store(v.typ, sc);
    end else begin
      wait_bursts(2);
      pulse_store(v.typ, sc);
      if (v.mode == 2) begin
        repeat (5) @(negedge clk);
        chk("ovr_before_2nd", store_overrun, 0);
        pulse_store(~v.typ, sc);
      end
    end
    n = 0;
    while (fd_cnt == fd0 && n < 20000) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("frame_done_seen", fd_cnt, fd0 + 1);
    chk("fd_buf", fd_buf, v.exp_buf);
    chk("fd_type", fd_type, v.typ);
    if (v.mode == 1)
      chk("fd_after_store", fd_cyc - sc, 1);
    else
      chk("fd_after_last_b", fd_cyc - last_b_cyc, 2);
    chk("aw_count", aw_q.size(), BPF);
    for (int i = 0; i < BPF && i < aw_q.size(); i++)
      chk("awaddr", aw_q[i], v.exp_addr + 32'(i) * 32'h400);
    chk("beats", frame_beats, FW);
    chk("resp_err", resp_err, v.exp_rerr);
    chk("store_overrun", store_overrun, v.exp_ovr);
  endtask

  initial begin
    fvec_t rv;
    tbl[0] = '{0, 99, 0, 0, FT_3D, 2'd0, 32'h8000_0000, 0, 0};
    tbl[1] = '{0, 99, 0, 0, FT_2D, 2'd1, 32'h8020_0000, 0, 0};
    tbl[2] = '{1, 99, 0, 1, FT_3D, 2'd2, 32'h8040_0000, 0, 0};
    tbl[3] = '{0, 7,  0, 0, FT_2D, 2'd3, 32'h8060_0000, 1, 0};
    tbl[4] = '{0, 99, 1, 0, FT_3D, 2'd0, 32'h8000_0000, 1, 0};
    tbl[5] = '{0, 99, 2, 0, FT_2D, 2'd1, 32'h8020_0000, 1, 1};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_wvalid", m_axi_wvalid, 0);
    chk("rst_bready", m_axi_bready, 0);
    chk("rst_fifo_rden", fifo_rden, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_awlen", m_axi_awlen, 8'hFF);
    chk("rst_awsize", m_axi_awsize, 3'b010);
    chk("rst_awburst", m_axi_awburst, 2'b01);
    chk("rst_wstrb", m_axi_wstrb, 4'hF);

    for (int r = 0; r < 6; r++) run_frame(tbl[r]);
    chk("fifo_underrun", fifo_underrun, 0);

    // Reset in the middle of burst 3's data phase.
    bp_en = 0;
    err_burst = 99;
    enable = 1'b1;
    pushed += FW;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (burst_idx == 3 && beat >= 10) break;
    end
    chk("reset_point_burst", burst_idx, 3);
    rst_n = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("mrst_awvalid", m_axi_awvalid, 0);
    chk("mrst_wvalid", m_axi_wvalid, 0);
    chk("mrst_bready", m_axi_bready, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_resp_err", resp_err, 0);
    chk("mrst_overrun", store_overrun, 0);
    rv = '{0, 99, 0, 0, FT_3D, 2'd0, 32'h8000_0000, 0, 0};
    run_frame(rv);
    chk("fifo_underrun_end", fifo_underrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
